// File: rtl/conv1d_pkg.sv
// Shared constants for the 1-D convolution MAC engine: default parameters,
// command opcodes and the controller state encoding.
package conv1d_pkg;

    localparam int DEF_DATA_W        = 8;
    localparam int DEF_ACC_W         = 32;
    localparam int DEF_KERNEL_LENGTH = 8;
    localparam int DEF_MAX_CHANNELS  = 128;
    localparam int DEF_LANES         = 4;

    localparam logic [6:0] OP_SOFT_RESET = 7'd0;
    localparam logic [6:0] OP_WR_INPUT   = 7'd10;
    localparam logic [6:0] OP_WR_WEIGHT  = 7'd11;
    localparam logic [6:0] OP_RD_INPUT   = 7'd13;
    localparam logic [6:0] OP_RD_WEIGHT  = 7'd14;
    localparam logic [6:0] OP_SET_OFFSET = 7'd20;
    localparam logic [6:0] OP_SET_WIDTH  = 7'd25;
    localparam logic [6:0] OP_SET_DEPTH  = 7'd26;
    localparam logic [6:0] OP_RUN        = 7'd41;
    localparam logic [6:0] OP_STATUS     = 7'd42;
    localparam logic [6:0] OP_RD_ACC     = 7'd43;
    localparam logic [6:0] OP_SET_START  = 7'd44;
    localparam logic [6:0] OP_PUSH_COL   = 7'd45;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        RESP    = 2'd2
    } state_t;

endpackage

// File: rtl/conv1d_mac_lanes.sv
// Combinational MAC slice: LANES signed multipliers feeding a binary adder
// tree. Disabled lanes contribute zero so a partial final step is exact.
module conv1d_mac_lanes
    import conv1d_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LANES  = DEF_LANES
) (
    input  logic signed [DATA_W-1:0] weight  [LANES],
    input  logic signed [ACC_W-1:0]  operand [LANES],
    input  logic        [LANES-1:0]  lane_en,
    output logic signed [ACC_W-1:0]  sum
);

    localparam int PROD_W = DATA_W + ACC_W;
    localparam int LEAVES = 1 << $clog2(LANES);

    logic signed [PROD_W-1:0] prod [LANES];
    logic        [LANES-1:0]  prod_hi_unused;
    logic signed [ACC_W-1:0]  node [2*LEAVES-1];

    // Full-width signed products; the accumulator wraps, so only the low
    // ACC_W bits of each product feed the tree.
    always_comb begin
        // NOTE: every variable gets a default before any conditional or loop
        // assignment, so no path leaves it holding state (no latch).
        prod_hi_unused = '0;
        for (int i = 0; i < LANES; i++) begin
            prod[i]           = weight[i] * operand[i];
            prod_hi_unused[i] = ^prod[i][PROD_W-1:ACC_W];
        end
    end

    // Pad the leaf row to a power of two and reduce pairwise toward node 0.
    always_comb begin
        for (int i = 0; i < 2*LEAVES-1; i++) node[i] = '0;
        for (int i = 0; i < LANES; i++)
            node[LEAVES-1+i] = lane_en[i] ? prod[i][ACC_W-1:0] : '0;
        for (int i = LEAVES-2; i >= 0; i--)
            node[i] = node[2*i+1] + node[2*i+2];
        sum = node[0];
    end

endmodule

// File: rtl/conv1d_mac_engine.sv
// Command-driven 1-D convolution engine: input/weight buffers, a ring-indexed
// kernel window and a LANES-wide MAC that accumulates one filter response.
module conv1d_mac_engine
    import conv1d_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int ACC_W         = DEF_ACC_W,
    parameter int KERNEL_LENGTH = DEF_KERNEL_LENGTH,
    parameter int MAX_CHANNELS  = DEF_MAX_CHANNELS,
    parameter int LANES         = DEF_LANES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [6:0]  cmd,
    input  logic [31:0] inp0,
    input  logic [31:0] inp1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_out
);

    localparam int BUF_DEPTH = KERNEL_LENGTH * MAX_CHANNELS;
    localparam int ADDR_W    = $clog2(BUF_DEPTH);
    localparam int IDX_W     = ADDR_W + 2;
    localparam int K_W       = $clog2(KERNEL_LENGTH);
    localparam int DEPTH_W   = $clog2(MAX_CHANNELS + 1);

    state_t                    state, next_state;
    logic signed [DATA_W-1:0]  in_buf [BUF_DEPTH];
    logic signed [DATA_W-1:0]  w_buf  [BUF_DEPTH];
    logic signed [ACC_W-1:0]   acc, input_offset, lane_sum;
    logic        [31:0]        width, cmd_result;
    logic        [DEPTH_W-1:0] depth;
    logic        [K_W-1:0]     start_x;
    logic        [IDX_W-1:0]   k, total, base, base_now;
    logic        [32:0]        push_slot;
    logic                      accept, addr_ok, push_ok, push_wrap, last_step, busy;
    logic                      in_we, w_we, unused_width;
    logic        [ADDR_W-1:0]  in_waddr, w_waddr;
    logic signed [DATA_W-1:0]  lane_w [LANES];
    logic signed [ACC_W-1:0]   lane_x [LANES];
    logic        [LANES-1:0]   lane_en;

    // width is bookkeeping for software only; nothing in the datapath reads it.
    assign unused_width = ^width;

    assign busy      = (state == COMPUTE);
    assign accept    = (state == IDLE) && cmd_valid && !reset;
    assign addr_ok   = inp0 < 32'(BUF_DEPTH);
    assign base_now  = IDX_W'(start_x) * IDX_W'(depth);
    assign push_slot = 33'(base_now) + 33'(inp0);
    assign push_ok   = push_slot < 33'(BUF_DEPTH);
    assign push_wrap = (33'(inp0) + 33'd1) == 33'(depth);
    assign last_step = (k + IDX_W'(LANES)) >= total;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state and handshake decode.
    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) next_state = (cmd == OP_RUN && depth != '0) ? COMPUTE : RESP;
            end
            COMPUTE: if (last_step) next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Immediate response value for single-cycle commands.
    always_comb begin
        cmd_result = '0;
        case (cmd)
            OP_RD_INPUT:  if (addr_ok) cmd_result = 32'(in_buf[inp0[ADDR_W-1:0]]);
            OP_RD_WEIGHT: if (addr_ok) cmd_result = 32'(w_buf[inp0[ADDR_W-1:0]]);
            OP_STATUS:    cmd_result = {31'b0, busy};
            OP_RD_ACC:    cmd_result = 32'(acc);
            default:      cmd_result = '0;
        endcase
    end

    // Buffer write decode; out-of-range addresses simply drop the write.
    always_comb begin
        in_we    = 1'b0;
        w_we     = 1'b0;
        in_waddr = inp0[ADDR_W-1:0];
        w_waddr  = inp0[ADDR_W-1:0];
        if (accept) begin
            case (cmd)
                OP_WR_INPUT:  in_we = addr_ok;
                OP_WR_WEIGHT: w_we  = addr_ok;
                OP_PUSH_COL: begin
                    in_we    = push_ok;
                    in_waddr = push_slot[ADDR_W-1:0];
                end
                default: ;
            endcase
        end
    end

    // Buffer storage.
    always_ff @(posedge clk) begin
        // NOTE: the buffers are intentionally not reset; clearing thousands of
        // entries would need a multi-cycle sweep and software reloads them anyway.
        if (in_we) in_buf[in_waddr] <= inp1[DATA_W-1:0];
        if (w_we)  w_buf[w_waddr]   <= inp1[DATA_W-1:0];
    end

    // Lane operand fetch: weight index k+l walks the filter linearly, and the
    // matching input sits start_x columns further along the ring of columns.
    always_comb begin
        logic [IDX_W-1:0] widx, iidx;
        widx    = '0;
        iidx    = '0;
        lane_en = '0;
        for (int l = 0; l < LANES; l++) begin
            widx = k + IDX_W'(l);
            iidx = widx + base;
            if (iidx >= total) iidx = iidx - total;
            lane_en[l] = widx < total;
            if (!lane_en[l]) begin
                widx = '0;
                iidx = '0;
            end
            lane_w[l] = w_buf[widx[ADDR_W-1:0]];
            lane_x[l] = ACC_W'(in_buf[iidx[ADDR_W-1:0]]) + input_offset;
        end
    end

    conv1d_mac_lanes #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .LANES  (LANES)
    ) u_lanes (
        .weight  (lane_w),
        .operand (lane_x),
        .lane_en (lane_en),
        .sum     (lane_sum)
    );

    // Configuration registers, accumulator and response register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid    <= 1'b0;
            rsp_out      <= '0;
            acc          <= '0;
            input_offset <= '0;
            depth        <= '0;
            width        <= '0;
            start_x      <= '0;
            k            <= '0;
            total        <= '0;
            base         <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    rsp_out   <= cmd_result;
                    rsp_valid <= !(cmd == OP_RUN && depth != '0);
                    case (cmd)
                        OP_SOFT_RESET: begin
                            acc          <= '0;
                            input_offset <= '0;
                            depth        <= '0;
                            width        <= '0;
                            start_x      <= '0;
                        end
                        OP_SET_OFFSET: input_offset <= ACC_W'($signed(inp1));
                        OP_SET_WIDTH:  width <= inp1;
                        OP_SET_DEPTH:  depth <= (inp1 > 32'(MAX_CHANNELS)) ? DEPTH_W'(MAX_CHANNELS)
                                                                            : inp1[DEPTH_W-1:0];
                        OP_SET_START:  start_x <= inp1[K_W-1:0];
                        OP_PUSH_COL:   if (push_wrap) start_x <= start_x + K_W'(1);
                        OP_RUN: begin
                            acc   <= '0;
                            k     <= '0;
                            total <= IDX_W'(depth) << K_W;
                            base  <= base_now;
                        end
                        default: ;
                    endcase
                end
                COMPUTE: begin
                    acc <= acc + lane_sum;
                    k   <= k + IDX_W'(LANES);
                    if (last_step) begin
                        rsp_valid <= 1'b1;
                        rsp_out   <= 32'(acc + lane_sum);
                    end
                end
                RESP: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv1d_mac_engine.sv
// Directed-plus-random bench for conv1d_mac_engine against a plain-arithmetic
// convolution model.
module tb_conv1d_mac_engine;
    import conv1d_pkg::*;

    localparam int K     = 8;
    localparam int MAXC  = 128;
    localparam int LANES = 4;
    localparam int BUF   = K * MAXC;

    logic        clk = 1'b0;
    logic        reset, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [6:0]  cmd;
    logic [31:0] inp0, inp1, rsp_out;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model state.
    int m_in [BUF];
    int m_w  [BUF];
    int m_off, m_depth, m_sx, m_acc;

    always #5 clk = ~clk;

    conv1d_mac_engine dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .inp0      (inp0),
        .inp1      (inp1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_out   (rsp_out)
    );

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    function automatic int sext8(input logic [31:0] v);
        return int'(byte'(v));
    endfunction

    // Convolution straight from the definition of the filter response.
    function automatic int model_acc();
        int s = 0;
        for (int f = 0; f < K; f++)
            for (int c = 0; c < m_depth; c++)
                s += m_w[f*m_depth + c] * (m_in[((f + m_sx) % K)*m_depth + c] + m_off);
        return s;
    endfunction

    task automatic send(input logic [6:0] op, input logic [31:0] a, input logic [31:0] v,
                        output logic [31:0] r, output int lat);
        @(negedge clk);
        cmd = op; inp0 = a; inp1 = v; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 2000) begin
            @(posedge clk);
            #1 lat++;
        end
        r = rsp_out;
        if (!rsp_valid) check("rsp_timeout", {31'b0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic op_only(input logic [6:0] op, input logic [31:0] a, input logic [31:0] v);
        logic [31:0] r;
        int lat;
        send(op, a, v, r, lat);
    endtask

    task automatic wr_in(input int a, input logic [31:0] v);
        op_only(OP_WR_INPUT, a, v);
        if (a < BUF) m_in[a] = sext8(v);
    endtask

    task automatic wr_w(input int a, input logic [31:0] v);
        op_only(OP_WR_WEIGHT, a, v);
        if (a < BUF) m_w[a] = sext8(v);
    endtask

    task automatic set_depth(input int v);
        op_only(OP_SET_DEPTH, 0, v);
        m_depth = (v > MAXC) ? MAXC : v;
    endtask

    task automatic set_start(input int v);
        op_only(OP_SET_START, 0, v);
        m_sx = v % K;
    endtask

    task automatic set_offset(input logic [31:0] v);
        op_only(OP_SET_OFFSET, 0, v);
        m_off = int'(v);
    endtask

    task automatic push(input int a, input logic [31:0] v);
        int slot;
        op_only(OP_PUSH_COL, a, v);
        slot = m_sx*m_depth + a;
        if (slot < BUF) m_in[slot] = sext8(v);
        if (a + 1 == m_depth) m_sx = (m_sx + 1) % K;
    endtask

    task automatic run_check(input string tag);
        logic [31:0] r;
        int lat;
        send(OP_RUN, 0, 0, r, lat);
        m_acc = model_acc();
        check(tag, r, m_acc);
        check({tag, "_latency"}, lat, (K*m_depth + LANES - 1)/LANES + 1);
    endtask

    task automatic read_check(input string tag, input logic [6:0] op, input logic [31:0] a,
                              input logic [31:0] exp);
        logic [31:0] r;
        int lat;
        send(op, a, 0, r, lat);
        check(tag, r, exp);
    endtask

    initial begin
        logic [31:0] r, col9_v0, col9_v1;
        int lat, d;

        reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd = '0; inp0 = '0; inp1 = '0;
        m_off = 0; m_depth = 0; m_sx = 0; m_acc = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_rsp_out", rsp_out, 32'd0);
        check("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        @(negedge clk) reset = 1'b0;
        send(OP_RD_ACC, 0, 0, r, lat);
        check("reset_acc", r, 32'd0);
        check("single_cycle_latency", lat, 32'd1);

        // Depth 1, unit weights, inputs 0..7 -> 28 in 3 cycles.
        set_depth(1); set_offset(0); set_start(0);
        for (int i = 0; i < K; i++) begin
            wr_w(i, 1);
            wr_in(i, i);
        end
        run_check("unit_weights_sum");

        // Start column 11 wraps to 3; only tap 0 weighted by 2 -> 2*in[3] = 6.
        set_start(11);
        wr_w(0, 2);
        for (int i = 1; i < K; i++) wr_w(i, 0);
        run_check("start_x_tap");

        // Buffer readback, sign extension and address bounds.
        read_check("rd_input", OP_RD_INPUT, 5, 32'd5);
        read_check("rd_weight", OP_RD_WEIGHT, 0, 32'd2);
        wr_w(3, 32'h0000_00F0);
        read_check("rd_weight_sext", OP_RD_WEIGHT, 3, 32'hFFFF_FFF0);
        wr_in(BUF, 99);
        read_check("oor_write_no_alias", OP_RD_INPUT, 0, 32'd0);
        read_check("oor_read_input", OP_RD_INPUT, BUF, 32'd0);
        read_check("oor_read_weight", OP_RD_WEIGHT, 32'hFFFF_FFFF, 32'd0);
        read_check("unknown_opcode", 7'd99, 0, 32'd0);
        read_check("set_width_rsp", OP_SET_WIDTH, 0, 32'd0);
        read_check("status_idle", OP_STATUS, 0, 32'd0);
        read_check("last_acc", OP_RD_ACC, 0, 32'd6);

        // Depth 0 skips computing entirely.
        set_depth(0);
        run_check("depth0_run");

        // Randomised windows against the model.
        for (int t = 0; t < 4; t++) begin
            d = $urandom_range(1, 6);
            set_depth(d);
            for (int i = 0; i < K*d; i++) begin
                wr_w(i, $urandom);
                wr_in(i, $urandom);
            end
            set_offset($urandom);
            set_start($urandom_range(0, 31));
            run_check($sformatf("random_run%0d", t));
        end

        // Full-depth worst case; depth request of 200 clamps to 128.
        set_depth(200); set_offset(128); set_start(0);
        for (int i = 0; i < BUF; i++) begin
            wr_w(i, 32'hFFFF_FF80);
            wr_in(i, 127);
        end
        run_check("full_depth");
        check("full_depth_const", m_acc, -33423360);

        // Held response under rsp_ready low.
        @(negedge clk);
        cmd = OP_RD_ACC; inp0 = 0; inp1 = 0; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold_valid%0d", i), {31'b0, rsp_valid}, 32'd1);
            check($sformatf("hold_data%0d", i), rsp_out, m_acc);
            check($sformatf("hold_cmd_ready%0d", i), {31'b0, cmd_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check("hold_release_ready", {31'b0, cmd_ready}, 32'd1);

        // Column pushes at depth 2: nine columns wrap the ring once.
        set_depth(2); set_start(0); set_offset($urandom);
        for (int i = 0; i < K*2; i++) wr_w(i, $urandom);
        col9_v0 = '0; col9_v1 = '0;
        for (int col = 0; col < 9; col++) begin
            col9_v0 = $urandom;
            col9_v1 = $urandom;
            push(0, col9_v0);
            push(1, col9_v1);
        end
        read_check("push_slot0", OP_RD_INPUT, 0, sext8(col9_v0));
        read_check("push_slot1", OP_RD_INPUT, 1, sext8(col9_v1));
        run_check("push_ring_run");

        // Soft reset clears registers but leaves buffers.
        op_only(OP_SOFT_RESET, 0, 0);
        m_acc = 0; m_off = 0; m_depth = 0; m_sx = 0;
        read_check("soft_reset_acc", OP_RD_ACC, 0, 32'd0);
        run_check("soft_reset_depth0");
        set_depth(1);
        run_check("soft_reset_cleared_regs");

        // Reset in the middle of a long computation.
        set_depth(128);
        @(negedge clk);
        cmd = OP_RUN; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("abort_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        @(negedge clk) reset = 1'b0;
        m_acc = 0; m_off = 0; m_depth = 0; m_sx = 0;
        repeat (3) @(posedge clk);
        #1 check("abort_no_late_rsp", {31'b0, rsp_valid}, 32'd0);
        read_check("abort_acc", OP_RD_ACC, 0, 32'd0);
        run_check("abort_depth_cleared");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
